// File: rtl/commit_rob.sv
// In-order commit buffer: allocates transaction IDs at issue, gathers out-of-order
// write-back results and retires entries strictly in allocation order, one per cycle.
module commit_rob #(
  parameter int unsigned NR_WB_PORTS   = 4,
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  flush_i,
  input  logic                                  alloc_req_i,
  input  logic [4:0]                            alloc_rd_i,
  input  logic                                  alloc_we_i,
  output logic                                  alloc_gnt_o,
  output logic [TRANS_ID_BITS-1:0]              alloc_id_o,
  input  logic [NR_WB_PORTS-1:0]                wb_vld_i,
  input  logic [NR_WB_PORTS*TRANS_ID_BITS-1:0]  wb_id_i,
  input  logic [NR_WB_PORTS*DATA_WIDTH-1:0]     wb_data_i,
  output logic                                  commit_vld_o,
  output logic [TRANS_ID_BITS-1:0]              commit_id_o,
  output logic [4:0]                            commit_rd_o,
  output logic                                  commit_we_o,
  output logic [DATA_WIDTH-1:0]                 commit_data_o,
  output logic                                  full_o,
  output logic                                  empty_o,
  output logic                                  wb_err_o
);

  localparam int unsigned CW = TRANS_ID_BITS + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0]         done_q, done_d;
  logic [DEPTH-1:0]         we_q, we_d;
  logic [4:0]               rd_q [DEPTH];
  logic [4:0]               rd_d [DEPTH];
  logic [DATA_WIDTH-1:0]    data_q [DEPTH];
  logic [DATA_WIDTH-1:0]    data_d [DEPTH];
  logic [TRANS_ID_BITS-1:0] head_q, head_d;
  logic [TRANS_ID_BITS-1:0] tail_q, tail_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     wb_err_q, wb_err_d;

  logic                     gnt;
  logic                     commit;
  logic [TRANS_ID_BITS-1:0] wb_id [NR_WB_PORTS];
  logic [NR_WB_PORTS-1:0]   wb_dup;
  logic [NR_WB_PORTS-1:0]   wb_ok;
  logic                     wb_err_any;

  assign full_o      = (cnt_q == DEPTH_C);
  assign empty_o     = (cnt_q == '0);
  assign gnt         = alloc_req_i & ~full_o & ~flush_i;
  assign commit      = valid_q[head_q] & done_q[head_q] & ~flush_i;

  assign alloc_gnt_o   = gnt;
  assign alloc_id_o    = tail_q;
  assign commit_vld_o  = commit;
  assign commit_id_o   = head_q;
  assign commit_rd_o   = rd_q[head_q];
  assign commit_we_o   = we_q[head_q] & (rd_q[head_q] != 5'd0);
  assign commit_data_o = data_q[head_q];
  assign wb_err_o      = wb_err_q;

  // A slot granted this cycle still reads valid_q=0, so a write-back to it is rejected.
  always_comb begin
    for (int p = 0; p < NR_WB_PORTS; p++) begin
      wb_id[p] = wb_id_i[p*TRANS_ID_BITS +: TRANS_ID_BITS];
    end
    for (int p = 0; p < NR_WB_PORTS; p++) begin
      wb_dup[p] = 1'b0;
      for (int q = 0; q < p; q++) begin
        if (wb_vld_i[q] && (wb_id[q] == wb_id[p])) begin
          wb_dup[p] = 1'b1;
        end
      end
      wb_ok[p] = wb_vld_i[p] & ~wb_dup[p] & valid_q[wb_id[p]] & ~done_q[wb_id[p]];
    end
    wb_err_any = |(wb_vld_i & ~wb_ok);
  end

  always_comb begin
    valid_d  = valid_q;
    done_d   = done_q;
    we_d     = we_q;
    rd_d     = rd_q;
    data_d   = data_q;
    head_d   = head_q;
    tail_d   = tail_q;
    cnt_d    = cnt_q;
    wb_err_d = wb_err_q;

    if (flush_i) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      cnt_d   = '0;
    end else begin
      for (int p = 0; p < NR_WB_PORTS; p++) begin
        if (wb_ok[p]) begin
          done_d[wb_id[p]] = 1'b1;
          data_d[wb_id[p]] = wb_data_i[p*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      if (wb_err_any) begin
        wb_err_d = 1'b1;
      end
      if (commit) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + TRANS_ID_BITS'(1);
      end
      // Grant and commit never hit the same slot: the tail slot is free whenever not full.
      if (gnt) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        rd_d[tail_q]    = alloc_rd_i;
        we_d[tail_q]    = alloc_we_i;
        tail_d          = tail_q + TRANS_ID_BITS'(1);
      end
      cnt_d = cnt_q + CW'(gnt) - CW'(commit);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= '0;
      done_q   <= '0;
      we_q     <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      cnt_q    <= '0;
      wb_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      done_q   <= done_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
      wb_err_q <= wb_err_d;
    end
  end

endmodule

// File: tb/tb_commit_rob.sv
// Directed bench for commit_rob: a queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_commit_rob;
  localparam int NP = 4;
  localparam int D  = 8;
  localparam int IW = 3;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst, flush, req, we_in;
  logic [4:0]        rd_in;
  logic [NP-1:0]     wb_vld;
  logic [NP*IW-1:0]  wb_id;
  logic [NP*DW-1:0]  wb_data;
  logic              alloc_gnt_o, commit_vld_o, commit_we_o, full_o, empty_o, wb_err_o;
  logic [IW-1:0]     alloc_id_o, commit_id_o;
  logic [4:0]        commit_rd_o;
  logic [DW-1:0]     commit_data_o;

  always #5 clk = ~clk;

  commit_rob #(.NR_WB_PORTS(NP), .DEPTH(D), .TRANS_ID_BITS(IW), .DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .alloc_req_i(req), .alloc_rd_i(rd_in), .alloc_we_i(we_in),
    .alloc_gnt_o(alloc_gnt_o), .alloc_id_o(alloc_id_o),
    .wb_vld_i(wb_vld), .wb_id_i(wb_id), .wb_data_i(wb_data),
    .commit_vld_o(commit_vld_o), .commit_id_o(commit_id_o), .commit_rd_o(commit_rd_o),
    .commit_we_o(commit_we_o), .commit_data_o(commit_data_o),
    .full_o(full_o), .empty_o(empty_o), .wb_err_o(wb_err_o)
  );

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Model: ordered list of live IDs plus per-ID result storage.
  int          mq[$];
  bit          m_done [D];
  logic [4:0]  m_rd   [D];
  bit          m_we   [D];
  logic [DW-1:0] m_data [D];
  bit          m_err;
  int          m_tail;
  bit          m_init = 1'b0;

  function automatic bit in_q(int id);
    foreach (mq[i]) if (mq[i] == id) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    int  cnt, head, id;
    bit  e_gnt, e_cvld;
    bit  seen [D];
    cnt    = mq.size();
    head   = (m_tail - cnt + D) % D;
    e_gnt  = req && (cnt != D) && !flush;
    e_cvld = (cnt > 0) && m_done[mq[0]] && !flush;
    if (m_init) begin
      chk("alloc_gnt", 64'(alloc_gnt_o), 64'(e_gnt));
      chk("alloc_id", 64'(alloc_id_o), 64'(m_tail));
      chk("full", 64'(full_o), 64'(cnt == D));
      chk("empty", 64'(empty_o), 64'(cnt == 0));
      chk("commit_vld", 64'(commit_vld_o), 64'(e_cvld));
      chk("commit_id", 64'(commit_id_o), 64'(head));
      chk("commit_rd", 64'(commit_rd_o), 64'(m_rd[head]));
      chk("commit_we", 64'(commit_we_o), 64'(m_we[head] && m_rd[head] != 0));
      chk("commit_data", 64'(commit_data_o), 64'(m_data[head]));
      chk("wb_err", 64'(wb_err_o), 64'(m_err));
    end
    if (rst) begin
      mq.delete();
      for (int i = 0; i < D; i++) begin
        m_done[i] = 0; m_rd[i] = 0; m_we[i] = 0; m_data[i] = 0;
      end
      m_err  = 0;
      m_tail = 0;
      m_init = 1'b1;
    end else if (m_init) begin
      if (flush) begin
        mq.delete();
        m_tail = 0;
      end else begin
        for (int i = 0; i < D; i++) seen[i] = 0;
        for (int p = 0; p < NP; p++) begin
          if (wb_vld[p]) begin
            id = int'(wb_id[p*IW +: IW]);
            if (seen[id]) m_err = 1;
            else begin
              seen[id] = 1;
              if (!in_q(id) || m_done[id]) m_err = 1;
              else begin
                m_done[id] = 1;
                m_data[id] = wb_data[p*DW +: DW];
              end
            end
          end
        end
        if (e_cvld) void'(mq.pop_front());
        if (e_gnt) begin
          mq.push_back(m_tail);
          m_done[m_tail] = 0;
          m_rd[m_tail]   = rd_in;
          m_we[m_tail]   = we_in;
          m_tail         = (m_tail + 1) % D;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_wb();
    wb_vld  = '0;
    wb_id   = '0;
    wb_data = '0;
  endtask

  task automatic wb(input int p, input int id, input logic [DW-1:0] d);
    logic [IW-1:0] idb;
    idb = IW'(id);
    wb_vld[p]            = 1'b1;
    wb_id[p*IW +: IW]    = idb;
    wb_data[p*DW +: DW]  = d;
  endtask

  initial begin
    rst = 1; flush = 0; req = 0; we_in = 0; rd_in = 0;
    clr_wb();
    tick(); tick();
    rst = 0;
    @(negedge clk);
    chk("rst_empty", 64'(empty_o), 64'd1);
    chk("rst_alloc_id", 64'(alloc_id_o), 64'd0);
    chk("rst_cvld", 64'(commit_vld_o), 64'd0);
    chk("rst_data", 64'(commit_data_o), 64'd0);

    // three allocations, results in one cycle, back-to-back commits
    tick(); req = 1; we_in = 1; rd_in = 1;
    tick(); rd_in = 2;
    tick(); rd_in = 3;
    tick(); req = 0; wb(0, 0, 32'hA); wb(1, 1, 32'hB); wb(2, 2, 32'hC);
    tick(); clr_wb();
    @(negedge clk);
    chk("t1_c0_vld", 64'(commit_vld_o), 64'd1);
    chk("t1_c0_id", 64'(commit_id_o), 64'd0);
    chk("t1_c0_data", 64'(commit_data_o), 64'hA);
    tick(); @(negedge clk);
    chk("t1_c1_data", 64'(commit_data_o), 64'hB);
    tick(); @(negedge clk);
    chk("t1_c2_data", 64'(commit_data_o), 64'hC);
    tick(); @(negedge clk);
    chk("t1_empty", 64'(empty_o), 64'd1);

    // out-of-order completion holds retirement
    tick(); rst = 1;
    tick(); rst = 0; req = 1; rd_in = 4;
    tick(); rd_in = 5;
    tick(); req = 0; wb(0, 1, 32'h55);
    tick(); clr_wb(); @(negedge clk);
    chk("t2_t1_vld", 64'(commit_vld_o), 64'd0);
    tick(); wb(0, 0, 32'h44); @(negedge clk);
    chk("t2_t2_vld", 64'(commit_vld_o), 64'd0);
    tick(); clr_wb(); @(negedge clk);
    chk("t2_t3_data", 64'(commit_data_o), 64'h44);
    chk("t2_t3_vld", 64'(commit_vld_o), 64'd1);
    tick(); @(negedge clk);
    chk("t2_t4_id", 64'(commit_id_o), 64'd1);
    chk("t2_t4_data", 64'(commit_data_o), 64'h55);

    // fill, full, wrap-around grant one cycle after the freeing commit
    tick(); rst = 1;
    tick(); rst = 0; req = 1;
    for (int i = 0; i < D; i++) begin
      rd_in = 5'(i + 1);
      tick();
    end
    rd_in = 9; wb(0, 0, 32'h99); @(negedge clk);
    chk("t3_full", 64'(full_o), 64'd1);
    chk("t3_gnt9", 64'(alloc_gnt_o), 64'd0);
    tick(); clr_wb(); @(negedge clk);
    chk("t3_cvld", 64'(commit_vld_o), 64'd1);
    chk("t3_gnt_commit_cycle", 64'(alloc_gnt_o), 64'd0);
    tick(); @(negedge clk);
    chk("t3_gnt_next", 64'(alloc_gnt_o), 64'd1);
    chk("t3_wrap_id", 64'(alloc_id_o), 64'd0);
    tick(); req = 0;

    // flush overrides alloc, write-back and commit
    tick(); rst = 1;
    tick(); rst = 0; req = 1; rd_in = 10;
    tick(); tick(); tick();
    tick(); req = 0; wb(0, 0, 32'h1); wb(1, 1, 32'h2);
    tick(); clr_wb(); flush = 1; req = 1; wb(0, 2, 32'h3); @(negedge clk);
    chk("t4_flush_gnt", 64'(alloc_gnt_o), 64'd0);
    chk("t4_flush_cvld", 64'(commit_vld_o), 64'd0);
    tick(); flush = 0; req = 0; clr_wb(); @(negedge clk);
    chk("t4_empty", 64'(empty_o), 64'd1);
    tick(); req = 1; rd_in = 12; @(negedge clk);
    chk("t4_realloc_gnt", 64'(alloc_gnt_o), 64'd1);
    chk("t4_realloc_id", 64'(alloc_id_o), 64'd0);
    tick(); req = 0;

    // sticky error: unallocated target survives flush, cleared by reset
    wb(0, 5, 32'hDEAD);
    tick(); clr_wb(); @(negedge clk);
    chk("t5_err", 64'(wb_err_o), 64'd1);
    tick(); flush = 1;
    tick(); flush = 0; @(negedge clk);
    chk("t5_err_flush", 64'(wb_err_o), 64'd1);
    tick(); rst = 1;
    tick(); rst = 0; @(negedge clk);
    chk("t5_err_rst", 64'(wb_err_o), 64'd0);

    // same ID on two ports: lowest port wins
    tick(); req = 1; we_in = 1; rd_in = 7;
    tick(); rd_in = 8;
    tick(); req = 0; wb(0, 1, 32'h11); wb(1, 0, 32'h33); wb(2, 1, 32'h22);
    tick(); clr_wb(); @(negedge clk);
    chk("t6_err", 64'(wb_err_o), 64'd1);
    chk("t6_c0_data", 64'(commit_data_o), 64'h33);
    tick(); @(negedge clk);
    chk("t6_c1_vld", 64'(commit_vld_o), 64'd1);
    chk("t6_c1_data", 64'(commit_data_o), 64'h11);

    // write-enable qualification by rd and we
    tick(); req = 1; rd_in = 0; we_in = 1;
    tick(); rd_in = 5; we_in = 0;
    tick(); rd_in = 6; we_in = 1;
    tick(); req = 0; wb(0, 2, 32'h1); wb(1, 3, 32'h2); wb(2, 4, 32'h3);
    tick(); clr_wb(); @(negedge clk);
    chk("t7_rd0_vld", 64'(commit_vld_o), 64'd1);
    chk("t7_rd0_we", 64'(commit_we_o), 64'd0);
    tick(); @(negedge clk);
    chk("t7_we0_rd", 64'(commit_rd_o), 64'd5);
    chk("t7_we0_we", 64'(commit_we_o), 64'd0);
    tick(); @(negedge clk);
    chk("t7_we1_we", 64'(commit_we_o), 64'd1);
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/commit_rob.md
# commit_rob

In-order commit buffer sitting directly downstream of the execute stage. It allocates a transaction ID to every issued instruction, collects out-of-order results from the execute write-back ports (CSR, ALU, LSU, MUL/DIV), and retires them strictly in allocation order, one per cycle, toward the register file. A flush discards every in-flight entry.

## Interface
Parameters:
- NR_WB_PORTS, 4, number of write-back ports from execute
- DEPTH, 8, number of entries; must be a power of two, at least 2
- TRANS_ID_BITS, 3, ID width; equals log2(DEPTH)
- DATA_WIDTH, 32, result width

Ports:
- clk_i  in  1  clock; all state updates on its rising edge
- rst_i  in  1  reset, synchronous, active-high
- flush_i  in  1  discard all entries
- alloc_req_i  in  1  issue requests an entry
- alloc_rd_i  in  5  destination register of the instruction
- alloc_we_i  in  1  instruction writes a register
- alloc_gnt_o  out  1  entry granted this cycle
- alloc_id_o  out  TRANS_ID_BITS  ID of the granted entry (tail pointer)
- wb_vld_i  in  NR_WB_PORTS  per-port result valid
- wb_id_i  in  NR_WB_PORTS*TRANS_ID_BITS  per-port ID; port p occupies bits [p*TRANS_ID_BITS +: TRANS_ID_BITS]
- wb_data_i  in  NR_WB_PORTS*DATA_WIDTH  per-port result; packed the same way
- commit_vld_o  out  1  head entry retires this cycle
- commit_id_o  out  TRANS_ID_BITS  head ID
- commit_rd_o  out  5  head destination register
- commit_we_o  out  1  register write enable (stored we AND rd != 0)
- commit_data_o  out  DATA_WIDTH  head result
- full_o  out  1  count == DEPTH
- empty_o  out  1  count == 0
- wb_err_o  out  1  sticky protocol-error flag

## Operation
- Per-entry state: valid, done, rd, we, data. Pointers: head, tail (TRANS_ID_BITS, natural wrap). count: TRANS_ID_BITS+1 bits, range 0..DEPTH.
- Allocation: alloc_gnt_o = alloc_req_i & !full_o & !flush_i. On grant, entry[tail] is loaded with valid=1, done=0, rd, we; tail increments. alloc_id_o always shows tail.
- A slot freed by a commit in the same cycle is not reusable until the next cycle. The full decision uses the current count only.
- Write-back: for each port with wb_vld_i set, a target entry that is valid and not done is loaded with done=1 and the port's data.
- Write-back errors: a target entry that is invalid or already done is ignored and sets wb_err_o. Two ports with the same ID in one cycle: the lowest port index wins, and wb_err_o is set.
- A write-back to an entry allocated in that same cycle counts as invalid: it is ignored and sets the error flag.
- Commit: commit_vld_o = entry[head].valid & entry[head].done & !flush_i. Commit outputs are combinational from the head entry's registered state. On commit, entry[head].valid is cleared and head increments.
- count next = count + grant - commit.
- Flush: clears all valid/done bits, head, tail and count. Flush overrides allocation, write-back and commit in the same cycle. wb_err_o is unaffected.
- Reset: same effect as flush, and also clears wb_err_o. Reset overrides flush.
- Output values after reset: alloc_gnt_o=0, alloc_id_o=0, commit_vld_o=0, commit_id_o=0, commit_rd_o=0, commit_we_o=0, commit_data_o=0, full_o=0, empty_o=1, wb_err_o=0. Entry rd/data registers are reset to 0.

## Timing
- Allocation: grant is combinational in the request cycle; the entry is valid from the next edge.
- Write-back to commit: a write-back accepted in cycle t makes the entry eligible for commit_vld_o in cycle t+1 at the earliest (one-cycle latency).
- Commit throughput: at most one commit per cycle.
- Back-to-back: consecutive entries that are already done commit on consecutive cycles.
- Simultaneous events: allocate + commit in the same cycle leaves count unchanged. When full, a commit in cycle t allows a grant in t+1.
- Wrap-around: head and tail wrap from DEPTH-1 to 0 with no gap.
- Full and empty are distinguished by count, not by pointer equality.

## Test plan
- Reset then allocate 3 (rd=1,2,3); write back IDs 0,1,2 in one cycle on ports 0,1,2 with data 0xA,0xB,0xC -> commits ID0/0xA, ID1/0xB, ID2/0xC on the next three consecutive cycles; empty_o=1 afterwards.
- Allocate IDs 0,1; write back ID1 (0x55) at t, then ID0 (0x44) at t+2 -> no commit before t+3; ID0/0x44 commits at t+3, ID1/0x55 at t+4.
- Fill 8 entries -> full_o=1 and a 9th request gets alloc_gnt_o=0. Complete ID0, then in its commit cycle hold alloc_req_i -> no grant that cycle; grant with alloc_id_o=0 (wrapped) the next cycle.
- Allocate 4, write back 2, assert flush_i for one cycle alongside alloc_req_i and a write-back -> alloc_gnt_o=0, commit_vld_o=0, empty_o=1 next cycle. The next allocation gets ID 0.
- Error handling:
  - Write-back to an unallocated ID -> wb_err_o=1, stays set through flush, cleared only by rst_i.
  - Ports 0 and 2 both target ID1 (data 0x11, 0x22) -> commit shows 0x11 and wb_err_o=1.
- Allocate with rd=0, we=1 -> on commit, commit_we_o=0.
- Allocate with rd=5, we=0 -> on commit, commit_we_o=0.
